qadd_pipe_array: RTL and testbench

- Second-generation fixed-point adder group. NUM independent lanes of N-bit sign-magnitude Q-format add/subtract.
- Operand A and B arrive on separate enables and are paired in hold registers. Each pair is issued into a LAT-stage pipeline.
- Adds per-lane add/subtract mode, input back-pressure (in_ready), output back-pressure (c_ready), a per-lane overflow flag, and a full-throughput stall-able pipeline.
- Sits between the operand fetch stage and the accumulator/writeback stage of the FM datapath.

---
 rtl/qadd_pipe_array.sv | 146 ++++++++++++++
 tb/tb_qadd_pipe_array.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/qadd_pipe_array.sv
// qadd_pipe_array: NUM lanes of N-bit sign-magnitude fixed-point add/subtract.
// Operands A and B arrive on separate strobes and pair up in hold registers.
// Each complete pair issues into a LAT-stage pipeline. The last stage drives c.
// The whole pipeline freezes while the output is valid and not accepted.
// Build option: define QADD_SAT_EN to clamp overflowing magnitudes to all-ones.
// Without it they wrap. The ovf flag is set in both builds.

module qadd_pipe_array #(
  parameter int unsigned Q   = 15,  // fractional bits, annotation only
  parameter int unsigned N   = 64,
  parameter int unsigned NUM = 4,
  parameter int unsigned LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*NUM-1:0] a,
  input  logic             a_en,
  input  logic [N*NUM-1:0] b,
  input  logic             b_en,
  input  logic [NUM-1:0]   sub,
  output logic             in_ready,
  output logic [N*NUM-1:0] c,
  output logic             c_valid,
  input  logic             c_ready,
  output logic [NUM-1:0]   ovf
);

  if (LAT == 0 || LAT > 8 || Q > N - 2) begin : g_param_check
    $error("qadd_pipe_array: LAT must be 1..8 and Q must fit in the magnitude");
  end

  // Per-lane sign-magnitude add. Returns {carry, sign, magnitude}.
  function automatic logic [N:0] lane_op(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic neg);
    logic [N-2:0] xm, ym, mag;
    logic         xs, ys, sign, carry;
    logic [N-1:0] sum;
    xm    = x[N-2:0];
    ym    = y[N-2:0];
    // A zero magnitude always counts as positive, so -0 behaves as +0.
    xs    = x[N-1] && (xm != '0);
    ys    = (y[N-1] ^ neg) && (ym != '0);
    carry = 1'b0;
    sum   = '0;
    if (xs == ys) begin
      sum   = {1'b0, xm} + {1'b0, ym};
      carry = sum[N-1];
      mag   = sum[N-2:0];
      sign  = xs;
`ifdef QADD_SAT_EN
      if (carry) mag = '1;
`endif
    end else if (xm > ym) begin
      mag  = xm - ym;
      sign = xs;
    end else if (ym > xm) begin
      mag  = ym - xm;
      sign = ys;
    end else begin
      // Exact cancellation always gives +0.
      mag  = '0;
      sign = 1'b0;
    end
    return {carry, sign, mag};
  endfunction

  logic [N*NUM-1:0] a_hold_q, b_hold_q;
  logic [NUM-1:0]   sub_hold_q;
  logic             a_held_q, b_held_q;

  logic [N*NUM-1:0] data_q [LAT];
  logic [NUM-1:0]   ovf_q  [LAT];
  logic             vld_q  [LAT];

  logic             stall, issue, a_cap, b_cap;
  logic [N*NUM-1:0] res;
  logic [NUM-1:0]   res_ovf;
  logic [N:0]       lane_res;

  assign c_valid  = vld_q[LAT-1];
  assign c        = data_q[LAT-1];
  assign ovf      = ovf_q[LAT-1];
  assign stall    = c_valid && !c_ready;
  assign issue    = a_held_q && b_held_q && !stall;
  assign in_ready = !(a_held_q && b_held_q) || issue;
  assign a_cap    = a_en && in_ready;
  assign b_cap    = b_en && in_ready;

  // Operand hold registers; a fresh strobe wins over the clear on issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_hold_q   <= '0;
      b_hold_q   <= '0;
      sub_hold_q <= '0;
      a_held_q   <= 1'b0;
      b_held_q   <= 1'b0;
    end else begin
      if (a_cap) begin
        a_hold_q <= a;
        a_held_q <= 1'b1;
      end else if (issue) begin
        a_held_q <= 1'b0;
      end
      if (b_cap) begin
        b_hold_q   <= b;
        sub_hold_q <= sub;
        b_held_q   <= 1'b1;
      end else if (issue) begin
        b_held_q <= 1'b0;
      end
    end
  end

  // Stage-1 arithmetic on the held pair, all lanes in parallel.
  always_comb begin
    res      = '0;
    res_ovf  = '0;
    lane_res = '0;
    for (int i = 0; i < NUM; i++) begin
      lane_res         = lane_op(a_hold_q[i*N +: N], b_hold_q[i*N +: N], sub_hold_q[i]);
      res[i*N +: N]    = lane_res[N-1:0];
      res_ovf[i]       = lane_res[N];
    end
  end

  // Pipeline: every stage advances together and freezes together on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin
        data_q[s] <= '0;
        ovf_q[s]  <= '0;
        vld_q[s]  <= 1'b0;
      end
    end else if (!stall) begin
      data_q[0] <= res;
      ovf_q[0]  <= res_ovf;
      vld_q[0]  <= issue;
      for (int s = 1; s < LAT; s++) begin
        data_q[s] <= data_q[s-1];
        ovf_q[s]  <= ovf_q[s-1];
        vld_q[s]  <= vld_q[s-1];
      end
    end
  end

endmodule

// File: tb/tb_qadd_pipe_array.sv
// Directed bench for qadd_pipe_array (N=64, NUM=4, LAT=2).
module tb_qadd_pipe_array;
  localparam int unsigned N   = 64;
  localparam int unsigned NUM = 4;
  localparam int unsigned LAT = 2;
  localparam int unsigned W   = N * NUM;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   a, b, c;
  logic           a_en, b_en, in_ready, c_valid, c_ready;
  logic [NUM-1:0] sub, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  qadd_pipe_array #(
    .Q  (15),
    .N  (N),
    .NUM(NUM),
    .LAT(LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .a_en    (a_en),
    .b       (b),
    .b_en    (b_en),
    .sub     (sub),
    .in_ready(in_ready),
    .c       (c),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .ovf     (ovf)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_en = 1'b0;
    b_en = 1'b0;
  endtask

  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [NUM-1:0] sv,
                       input logic ae, input logic be);
    a    = av;
    b    = bv;
    sub  = sv;
    a_en = ae;
    b_en = be;
  endtask

  logic [W-1:0] exp_x, exp_y;
  logic [N-1:0] l2_exp;
  logic [W-1:0] prev_c;
  logic         was_stalled, accepted;
  int           sent, got;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; a = '0; b = '0; sub = '0; a_en = 1'b0; b_en = 1'b0; c_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_c_valid", c_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_c", c, '0);
    check_eq("rst_ovf", ovf, '0);

    // Two back-to-back vectors: basic lanes, then sign/zero corner cases.
`ifdef QADD_SAT_EN
    l2_exp = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    l2_exp = 64'h7FFF_FFFF_FFFF_FFFE;
`endif
    exp_x = {64'h0, l2_exp, 64'h8000_0000_0000_8000, 64'h1_8000};
    exp_y = {64'h10, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0004, 64'h0};
    drive({64'h8000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000, 64'h8000},
          {64'h8000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1_0000, 64'h1_0000}, 4'b1010, 1'b1, 1'b1);
    tick();
    check_eq("lat_c1_valid", c_valid, 1'b0);
    check_eq("pair_in_ready", in_ready, 1'b1);
    drive({64'h10, 64'h8000_0000_0000_0003, 64'h5, 64'h8000_0000_0000_0000},
          {64'h8000_0000_0000_0000, 64'h8000_0000_0000_0002, 64'h8000_0000_0000_0009, 64'h0},
          4'b1100, 1'b1, 1'b1);
    tick();
    idle();
    check_eq("lat_c2_valid", c_valid, 1'b0);
    tick();
    check_eq("x_valid", c_valid, 1'b1);
    check_eq("x_c", c, exp_x);
    check_eq("x_ovf", ovf, 4'b0100);
    tick();
    check_eq("y_valid", c_valid, 1'b1);
    check_eq("y_c", c, exp_y);
    check_eq("y_ovf", ovf, 4'b0000);
    tick();
    check_eq("y_drop", c_valid, 1'b0);

    // Split strobes, A overwritten before B arrives.
    drive({4{64'h8000}}, '0, '0, 1'b1, 1'b0);
    tick();
    idle();
    check_eq("a_only_ready", in_ready, 1'b1);
    tick();
    drive({4{64'h2_0000}}, '0, '0, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    drive({4{64'h2_0000}}, {4{64'h1_0000}}, 4'b0000, 1'b0, 1'b1);
    tick();
    idle();
    check_eq("split_c5", c_valid, 1'b0);
    tick();
    check_eq("split_c6", c_valid, 1'b0);
    tick();
    check_eq("split_c7_valid", c_valid, 1'b1);
    check_eq("split_c7_c", c, {4{64'h3_0000}});
    tick();
    check_eq("split_c8_drop", c_valid, 1'b0);

    // Streaming with output back-pressure in cycles 4..6.
    sent = 0; got = 0; was_stalled = 1'b0; prev_c = '0; accepted = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      c_ready = !(cyc >= 4 && cyc <= 6);
      #1;
      if (was_stalled) begin
        check_eq("hold_valid", c_valid, 1'b1);
        check_eq("hold_c", c, prev_c);
      end
      if (cyc == 4) check_eq("full_in_ready", in_ready, 1'b0);
      if (cyc == 7) check_eq("resume_in_ready", in_ready, 1'b1);
      if (c_valid && c_ready) begin
        check_eq($sformatf("stream_%0d", got), c,
                 {4{64'((got + 1) * 64'h1000 + 64'h100)}});
        got++;
      end
      was_stalled = c_valid && !c_ready;
      prev_c = c;
      if (sent < 6) begin
        drive({4{64'((sent + 1) * 64'h1000)}}, {4{64'h100}}, 4'b0000, 1'b1, 1'b1);
        accepted = in_ready;
      end else begin
        idle();
        accepted = 1'b0;
      end
      tick();
      if (accepted) sent++;
    end
    idle();
    c_ready = 1'b1;
    check_eq("stream_count", got, 6);
    tick();
    check_eq("stream_drain", c_valid, 1'b0);

    // Reset with two vectors in flight, then a fresh pair.
    drive({4{64'h1000}}, {4{64'h1}}, 4'b0000, 1'b1, 1'b1);
    tick();
    drive({4{64'h2000}}, {4{64'h1}}, 4'b0000, 1'b1, 1'b1);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst2_c_valid", c_valid, 1'b0);
    check_eq("rst2_in_ready", in_ready, 1'b1);
    check_eq("rst2_c", c, '0);
    drive({4{64'h8000}}, {4{64'h3000}}, 4'b0101, 1'b1, 1'b1);
    tick();
    idle();
    check_eq("rst2_c4", c_valid, 1'b0);
    tick();
    check_eq("rst2_c5", c_valid, 1'b0);
    tick();
    check_eq("rst2_valid", c_valid, 1'b1);
    check_eq("rst2_result", c, {64'hB000, 64'h5000, 64'hB000, 64'h5000});
    check_eq("rst2_ovf", ovf, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
